// File: rtl/shift_pkg.sv
// Shared op codes and the per-level fill/wrap helper for the pipelined shifter.
package shift_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    // Widest datapath the fill helper handles; N must not exceed this.
    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_C = $clog2(MAX_N);

    // Bits entering the vacated end of an n-bit word shifted by shamt.
    // Only bits [shamt-1:0] of the result are meaningful; the caller
    // places them at the top (right shifts) or bottom (left shifts).
    function automatic logic [MAX_N-1:0] level_fill(
        input logic [MAX_N-1:0] data,
        input int unsigned      n,
        input int unsigned      shamt,
        input logic [2:0]       op
    );
        logic [MAX_N-1:0] fill;
        fill = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < shamt) begin
                case (op)
                    OP_ROL:  fill[i] = data[MAX_C'(n - shamt + i)];
                    OP_ROR:  fill[i] = data[MAX_C'(i)];
                    OP_SRA:  fill[i] = data[MAX_C'(n - 1)];
                    default: fill[i] = 1'b0;
                endcase
            end
        end
        return fill;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One power-of-two level of the shift network: shifts by SHAMT when enabled.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned SHAMT = 1
) (
    input  logic [N-1:0] i_data,
    input  logic         i_en,
    input  logic [2:0]   i_op,
    output logic [N-1:0] o_data
);

    logic [MAX_N-1:0] w_data_ext;
    logic [SHAMT-1:0] w_fill;

    assign w_data_ext = MAX_N'(i_data);
    assign w_fill     = SHAMT'(level_fill(w_data_ext, N, SHAMT, i_op));

    // Left ops shift toward the MSB, right ops toward the LSB; reserved ops pass through.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROL, OP_SLL:         o_data = {i_data[N-1-SHAMT:0], w_fill};
                OP_ROR, OP_SRL, OP_SRA: o_data = {w_fill, i_data[N-1:SHAMT]};
                default:                o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined log-level shifter/rotator with valid/ready on both sides.
// C shift levels are grouped LEVELS_PER_STAGE at a time between registers;
// a single advance enable stalls every stage together.
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter  int unsigned N                = 16,
    parameter  int unsigned LEVELS_PER_STAGE = 2,
    localparam int unsigned C                = $clog2(N),
    localparam int unsigned L                = (C + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    logic         w_adv;

    logic         r_valid [L];
    logic [N-1:0] r_data  [L];
    logic [C-1:0] r_cnt   [L];
    logic [2:0]   r_op    [L];

    // Inputs seen by each stage's combinational levels
    logic         w_stg_valid [L];
    logic [N-1:0] w_stg_data  [L];
    logic [C-1:0] w_stg_cnt   [L];
    logic [2:0]   w_stg_op    [L];
    // Data arriving at each stage register
    logic [N-1:0] w_stg_d     [L];

    logic [N-1:0] w_lvl_in  [C];
    logic [N-1:0] w_lvl_out [C];

    assign w_adv     = !r_valid[L-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[L-1];
    assign out_data  = r_data[L-1];

    assign w_stg_valid[0] = in_valid;
    assign w_stg_data[0]  = in_data;
    assign w_stg_cnt[0]   = in_cnt;
    assign w_stg_op[0]    = in_op;

    for (genvar s = 1; s < L; s++) begin : g_stg_in
        assign w_stg_valid[s] = r_valid[s-1];
        assign w_stg_data[s]  = r_data[s-1];
        assign w_stg_cnt[s]   = r_cnt[s-1];
        assign w_stg_op[s]    = r_op[s-1];
    end

    // Level j shifts by 2**j and belongs to stage j / LEVELS_PER_STAGE;
    // the first level of each stage takes that stage's registered input.
    for (genvar j = 0; j < C; j++) begin : g_level
        localparam int unsigned STG = j / LEVELS_PER_STAGE;
        if (j % LEVELS_PER_STAGE == 0) begin : g_first
            assign w_lvl_in[j] = w_stg_data[STG];
        end else begin : g_chain
            assign w_lvl_in[j] = w_lvl_out[j-1];
        end
        shift_level #(
            .N     (N),
            .SHAMT (1 << j)
        ) u_level (
            .i_data (w_lvl_in[j]),
            .i_en   (w_stg_cnt[STG][j]),
            .i_op   (w_stg_op[STG]),
            .o_data (w_lvl_out[j])
        );
    end

    for (genvar s = 0; s < L; s++) begin : g_stg_d
        localparam int unsigned LAST = ((s + 1) * LEVELS_PER_STAGE < C)
                                     ? (s + 1) * LEVELS_PER_STAGE - 1 : C - 1;
        assign w_stg_d[s] = w_lvl_out[LAST];
    end

    // All stages advance together whenever the output is free or being taken; bubbles advance too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < L; s++) begin
                r_valid[s] <= 1'b0;
                r_data[s]  <= '0;
                r_cnt[s]   <= '0;
                r_op[s]    <= '0;
            end
        end else if (w_adv) begin
            for (int unsigned s = 0; s < L; s++) begin
                r_valid[s] <= w_stg_valid[s];
                r_data[s]  <= w_stg_d[s];
                r_cnt[s]   <= w_stg_cnt[s];
                r_op[s]    <= w_stg_op[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench: directed tests on the N=16 unit, random sweep on four other configurations.
module tb_pipelined_shift_unit;

    localparam int L16  = 2;
    localparam int NCFG = 4;
    localparam int CFG_N [NCFG] = '{8, 32, 64, 32};
    localparam int CFG_L [NCFG] = '{3, 5, 6, 1};
    localparam int SWEEP_OPS = 2500;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  cnt;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    localparam vec_t VECS [10] = '{
        {3'b000, 4'd1,  16'h8001, 16'h0003},
        {3'b010, 4'd4,  16'h1234, 16'h4123},
        {3'b001, 4'd4,  16'h1234, 16'h2340},
        {3'b100, 4'd15, 16'h8000, 16'hFFFF},
        {3'b011, 4'd15, 16'h8000, 16'h0001},
        {3'b100, 4'd14, 16'h4000, 16'h0001},
        {3'b110, 4'd5,  16'hBEEF, 16'hBEEF},
        {3'b111, 4'd9,  16'h1234, 16'h1234},
        {3'b100, 4'd4,  16'hF0F0, 16'hFF0F},
        {3'b000, 4'd8,  16'hA5C3, 16'hC3A5}
    };

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic        sw_in_valid  [NCFG];
    logic        sw_in_ready  [NCFG];
    logic [63:0] sw_in_data   [NCFG];
    logic [5:0]  sw_in_cnt    [NCFG];
    logic [2:0]  sw_in_op     [NCFG];
    logic        sw_out_valid [NCFG];
    logic        sw_out_ready [NCFG];
    logic [63:0] sw_out_data  [NCFG];
    logic [7:0]  w_od8;
    logic [31:0] w_od32a;
    logic [63:0] w_od64;
    logic [31:0] w_od32b;

    int n_checks;
    int n_fail;

    assign sw_out_data[0] = 64'(w_od8);
    assign sw_out_data[1] = 64'(w_od32a);
    assign sw_out_data[2] = w_od64;
    assign sw_out_data[3] = 64'(w_od32b);

    pipelined_shift_unit #(.N(16), .LEVELS_PER_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipelined_shift_unit #(.N(8), .LEVELS_PER_STAGE(1)) u_sw8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
        .in_data(sw_in_data[0][7:0]), .in_cnt(sw_in_cnt[0][2:0]), .in_op(sw_in_op[0]),
        .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]), .out_data(w_od8)
    );

    pipelined_shift_unit #(.N(32), .LEVELS_PER_STAGE(1)) u_sw32a (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
        .in_data(sw_in_data[1][31:0]), .in_cnt(sw_in_cnt[1][4:0]), .in_op(sw_in_op[1]),
        .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]), .out_data(w_od32a)
    );

    pipelined_shift_unit #(.N(64), .LEVELS_PER_STAGE(1)) u_sw64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
        .in_data(sw_in_data[2]), .in_cnt(sw_in_cnt[2]), .in_op(sw_in_op[2]),
        .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]), .out_data(w_od64)
    );

    pipelined_shift_unit #(.N(32), .LEVELS_PER_STAGE(5)) u_sw32b (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]),
        .in_data(sw_in_data[3][31:0]), .in_cnt(sw_in_cnt[3][4:0]), .in_op(sw_in_op[3]),
        .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready[3]), .out_data(w_od32b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain arithmetic on an n-bit word held in 64 bits.
    function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int n,
                                              input int cnt, input logic [2:0] op);
        logic [63:0] mask, d, r;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        d = d_in & mask;
        case (op)
            3'd0: r = (d << cnt) | (d >> (n - cnt));
            3'd1: r = d << cnt;
            3'd2: r = (d >> cnt) | (d << (n - cnt));
            3'd3: r = d >> cnt;
            3'd4: begin
                r = d >> cnt;
                if (d[n-1]) r = r | (mask & ~(mask >> cnt));
            end
            default: r = d;
        endcase
        return r & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one item into the N=16 unit and report what came back and after how many edges.
    task automatic run_one(input logic [15:0] d, input logic [3:0] c, input logic [2:0] op,
                           output logic rdy, output logic [15:0] res, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_cnt    = c;
        in_op     = op;
        #1;
        rdy = in_ready;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        res = out_data;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h8001;
        in_cnt    = 4'd1;
        in_op     = 3'b000;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: got valid %b expected 1", out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async_data: got %h expected 0000", out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_valid: got %b expected 0", out_valid);
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic        rdy;
        logic [15:0] res;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_one(VECS[i].data, VECS[i].cnt, VECS[i].op, rdy, res, lat);
            n_checks++;
            if (rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_in_ready[%0d]: got %b expected 1", i, rdy);
            end
            n_checks++;
            if (lat != L16) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, L16);
            end
            n_checks++;
            if (res !== VECS[i].exp) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h expected %h", i, res, VECS[i].exp);
            end
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_retire[%0d]: got valid %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_cnt_zero();
        logic        rdy;
        logic [15:0] res;
        logic [15:0] d;
        int          lat;
        for (int op = 0; op < 8; op++) begin
            d = 16'($urandom);
            run_one(d, 4'd0, 3'(op), rdy, res, lat);
            n_checks++;
            if (res !== d || lat != L16) begin
                n_fail++;
                $display("FAIL cnt_zero[op%0d]: got %h lat %0d expected %h lat %0d",
                         op, res, lat, d, L16);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4];
        logic        acc, ret;
        logic [15:0] retdata;
        int sent, got, cyc;
        exp = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 4 && cyc < 40) begin
            in_valid  = (sent < 4);
            in_data   = 16'h0001;
            in_cnt    = 4'(sent + 1);
            in_op     = 3'b000;
            out_ready = (cyc >= 5);
            #1;
            if (cyc < 5 && out_valid === 1'b1) begin
                n_checks++;
                if (out_data !== 16'h0002) begin
                    n_fail++;
                    $display("FAIL stall_hold[cyc%0d]: got %h expected 0002", cyc, out_data);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_in_ready: got %b expected 0", in_ready);
                end
            end
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            retdata = out_data;
            tick();
            if (acc) sent++;
            if (ret) begin
                n_checks++;
                if (got >= 4 || retdata !== exp[got]) begin
                    n_fail++;
                    $display("FAIL drain_order[%0d]: got %h expected %h", got, retdata,
                             exp[got % 4]);
                end
                got++;
            end
            cyc++;
        end
        n_checks++;
        if (got != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL drain_count: got %0d retired %0d sent expected 4 and 4", got, sent);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_duplicate[%0d]: got valid %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic        rdy;
        logic [15:0] res;
        int          lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00FF;
        in_cnt    = 4'd4;
        in_op     = 3'b001;
        tick();
        in_data   = 16'h000F;
        in_cnt    = 4'd1;
        in_op     = 3'b010;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_flush[%0d]: got valid %b data %h expected 0",
                         i, out_valid, out_data);
            end
        end
        run_one(16'hF000, 4'd12, 3'b011, rdy, res, lat);
        n_checks++;
        if (res !== 16'h000F || lat != L16 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_next: got %h lat %0d rdy %b expected 000f lat %0d rdy 1",
                     res, lat, rdy, L16);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] q_data [NCFG][16];
        int          q_acc  [NCFG][16];
        int          head   [NCFG];
        int          qcnt   [NCFG];
        int          adv_cnt[NCFG];
        int          acc_n  [NCFG];
        logic        exp_v  [NCFG];
        logic        adv    [NCFG];
        logic [63:0] exp_d;
        int  cyc;
        bit  done;
        for (int k = 0; k < NCFG; k++) begin
            head[k] = 0; qcnt[k] = 0; adv_cnt[k] = 0; acc_n[k] = 0;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40000) begin
            for (int k = 0; k < NCFG; k++) begin
                exp_v[k] = (qcnt[k] > 0) && (adv_cnt[k] - q_acc[k][head[k]] == CFG_L[k] - 1);
                n_checks++;
                if (sw_out_valid[k] !== exp_v[k]) begin
                    n_fail++;
                    $display("FAIL sweep_valid[cfg%0d cyc%0d]: got %b expected %b",
                             k, cyc, sw_out_valid[k], exp_v[k]);
                end
                if (exp_v[k]) begin
                    n_checks++;
                    if (sw_out_data[k] !== q_data[k][head[k]]) begin
                        n_fail++;
                        $display("FAIL sweep_data[cfg%0d cyc%0d]: got %h expected %h",
                                 k, cyc, sw_out_data[k], q_data[k][head[k]]);
                    end
                end
                sw_out_ready[k] = ($urandom_range(0, 9) < 6);
                sw_in_valid[k]  = (acc_n[k] < SWEEP_OPS) && ($urandom_range(0, 9) < 7);
                sw_in_data[k]   = {$urandom, $urandom};
                sw_in_cnt[k]    = 6'($urandom_range(0, CFG_N[k] - 1));
                sw_in_op[k]     = 3'($urandom_range(0, 7));
            end
            #1;
            for (int k = 0; k < NCFG; k++) begin
                adv[k] = !exp_v[k] || sw_out_ready[k];
                n_checks++;
                if (sw_in_ready[k] !== adv[k]) begin
                    n_fail++;
                    $display("FAIL sweep_in_ready[cfg%0d cyc%0d]: got %b expected %b",
                             k, cyc, sw_in_ready[k], adv[k]);
                end
            end
            tick();
            for (int k = 0; k < NCFG; k++) begin
                if (adv[k]) adv_cnt[k]++;
                if (exp_v[k] && sw_out_ready[k]) begin
                    head[k] = (head[k] + 1) % 16;
                    qcnt[k]--;
                end
                if (sw_in_valid[k] && adv[k]) begin
                    exp_d = ref_shift(sw_in_data[k], CFG_N[k], int'(sw_in_cnt[k]), sw_in_op[k]);
                    q_data[k][(head[k] + qcnt[k]) % 16] = exp_d;
                    q_acc[k][(head[k] + qcnt[k]) % 16]  = adv_cnt[k];
                    qcnt[k]++;
                    acc_n[k]++;
                end
            end
            done = 1'b1;
            for (int k = 0; k < NCFG; k++)
                if (acc_n[k] < SWEEP_OPS || qcnt[k] != 0) done = 1'b0;
            cyc++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL sweep_complete: got unfinished after %0d cycles expected drained", cyc);
        end
        for (int k = 0; k < NCFG; k++) sw_in_valid[k] = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NCFG; k++) begin
            sw_in_valid[k]  = 1'b0;
            sw_in_data[k]   = '0;
            sw_in_cnt[k]    = '0;
            sw_in_op[k]     = '0;
            sw_out_ready[k] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        test_reset();
        test_basic();
        test_cnt_zero();
        test_back_to_back();
        test_reset_midstream();
        test_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
